hazard_forward_scoreboard: RTL

//  Next-generation hazard unit: per-operand forwarding selects, load-use stall, and a scoreboard for one out-of-band multdiv op.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/md_scoreboard_fsm.sv | 89 ++++++++
 rtl/hazard_forward_scoreboard.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and default sizes for the hazard / forwarding / multdiv scoreboard block.
package hazard_pkg;

    localparam int REG_W_DEF   = 5;
    localparam int EXC_REG_DEF = 30;
    localparam int MD_MAX_DEF  = 40;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_XM  = 2'b01,
        FWD_MW  = 2'b10,
        FWD_EXC = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/md_scoreboard_fsm.sv
// Tracks the single outstanding multdiv op: pending destination, watchdog, and the
// writeback slot that waits for a cycle in which the pipeline is not writing the RF.
module md_scoreboard_fsm
    import hazard_pkg::*;
#(
    parameter int REG_W  = REG_W_DEF,
    parameter int MD_MAX = MD_MAX_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             dx_is_md,
    input  logic [REG_W-1:0] dx_rd,
    input  logic             bubble_dx,
    input  logic             md_ready,
    input  logic             mw_wr_en,
    output md_state_e        state,
    output logic [REG_W-1:0] md_rd,
    output logic             md_wb_en,
    output logic             md_timeout
);

    localparam int WD_W = $clog2(MD_MAX + 1);

    md_state_e        state_q, state_d;
    logic [REG_W-1:0] md_rd_q, md_rd_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             wd_expired;

    assign wd_expired = (wd_q == WD_W'(MD_MAX));

    always_comb begin
        state_d    = state_q;
        md_rd_d    = md_rd_q;
        wd_d       = wd_q;
        md_wb_en   = 1'b0;
        md_timeout = 1'b0;
        case (state_q)
            MD_IDLE: begin
                // A bubbled DX slot holds no real instruction, so it must not claim the unit.
                if (dx_is_md && !bubble_dx) begin
                    state_d = MD_BUSY;
                    md_rd_d = dx_rd;
                    wd_d    = '0;
                end
            end
            MD_BUSY: begin
                if (wd_expired) begin
                    md_timeout = 1'b1;
                    state_d    = MD_IDLE;
                    md_rd_d    = '0;
                    wd_d       = '0;
                end else if (md_ready) begin
                    state_d = MD_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            MD_DONE: begin
                // The pipeline's own MW write owns the RF port; wait for a free cycle.
                if (!mw_wr_en) begin
                    md_wb_en = 1'b1;
                    state_d  = MD_IDLE;
                    md_rd_d  = '0;
                end
            end
            default: begin
                state_d = MD_IDLE;
                md_rd_d = '0;
                wd_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MD_IDLE;
            md_rd_q <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            md_rd_q <= md_rd_d;
            wd_q    <= wd_d;
        end
    end

    assign state = state_q;
    assign md_rd = md_rd_q;

endmodule

// File: rtl/hazard_forward_scoreboard.sv
// Hazard unit: ALU operand forwarding selects, load-use stall and multdiv scoreboard stall.
// Define HAZ_PERF_CNT_EN to add saturating stall / multdiv-occupancy performance counters.
module hazard_forward_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W   = REG_W_DEF,
    parameter int EXC_REG = EXC_REG_DEF,
    parameter int MD_MAX  = MD_MAX_DEF
`ifdef HAZ_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [REG_W-1:0] fd_rs1,
    input  logic [REG_W-1:0] fd_rs2,
    input  logic             fd_rs1_used,
    input  logic             fd_rs2_used,
    input  logic [REG_W-1:0] fd_rd,
    input  logic             fd_wr_en,
    input  logic             fd_is_md,
    input  logic [REG_W-1:0] dx_rs1,
    input  logic [REG_W-1:0] dx_rs2,
    input  logic             dx_rs1_used,
    input  logic             dx_rs2_used,
    input  logic [REG_W-1:0] dx_rd,
    input  logic             dx_wr_en,
    input  logic             dx_is_load,
    input  logic             dx_is_md,
    input  logic [REG_W-1:0] xm_rd,
    input  logic             xm_wr_en,
    input  logic             xm_exc,
    input  logic [REG_W-1:0] mw_rd,
    input  logic             mw_wr_en,
    input  logic             mw_exc,
    input  logic             md_ready,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall_fd,
    output logic             bubble_dx,
    output logic             md_busy,
    output logic [REG_W-1:0] md_rd,
    output logic             md_wb_en,
    output logic             md_timeout
`ifdef HAZ_PERF_CNT_EN
    , output logic [CNT_W-1:0] perf_stall_cnt
    , output logic [CNT_W-1:0] perf_md_cnt
`endif
);

    localparam logic [REG_W-1:0] EXC_IDX = REG_W'(EXC_REG);

    function automatic fwd_sel_e pick_fwd(
        input logic             used,
        input logic [REG_W-1:0] src,
        input logic             exc_any,
        input logic [REG_W-1:0] x_rd,
        input logic             x_we,
        input logic [REG_W-1:0] m_rd,
        input logic             m_we
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (used) begin
            if (src == EXC_IDX && exc_any)             sel = FWD_EXC;
            else if (src == x_rd && x_we && src != '0) sel = FWD_XM;
            else if (src == m_rd && m_we && src != '0) sel = FWD_MW;
        end
        return sel;
    endfunction

    md_state_e        md_state;
    logic [REG_W-1:0] md_rd_int;
    logic             md_wb_int, md_to_int, md_busy_int;
    logic             lu_hit, lu_stall, sb_stall, stall_int;
    logic             lu_q;
    fwd_sel_e         fwd_a, fwd_b;

    assign fwd_a = pick_fwd(dx_rs1_used, dx_rs1, xm_exc | mw_exc, xm_rd, xm_wr_en, mw_rd, mw_wr_en);
    assign fwd_b = pick_fwd(dx_rs2_used, dx_rs2, xm_exc | mw_exc, xm_rd, xm_wr_en, mw_rd, mw_wr_en);

    assign lu_hit = dx_is_load && dx_wr_en && (dx_rd != '0) &&
                    ((fd_rs1_used && fd_rs1 == dx_rd) || (fd_rs2_used && fd_rs2 == dx_rd));
    // One bubble resolves a load-use hazard, so never stall for it two cycles running.
    assign lu_stall = lu_hit && !lu_q;

    assign md_busy_int = (md_state != MD_IDLE);
    assign sb_stall    = md_busy_int &&
                         ((fd_rs1_used && fd_rs1 == md_rd_int && md_rd_int != '0) ||
                          (fd_rs2_used && fd_rs2 == md_rd_int && md_rd_int != '0) ||
                          (fd_wr_en && fd_rd == md_rd_int) ||
                          fd_is_md);
    assign stall_int = lu_stall || sb_stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) lu_q <= 1'b0;
        else          lu_q <= lu_stall;
    end

    md_scoreboard_fsm #(
        .REG_W  (REG_W),
        .MD_MAX (MD_MAX)
    ) u_md_fsm (
        .clock      (clock),
        .reset_n    (reset_n),
        .dx_is_md   (dx_is_md),
        .dx_rd      (dx_rd),
        .bubble_dx  (stall_int),
        .md_ready   (md_ready),
        .mw_wr_en   (mw_wr_en),
        .state      (md_state),
        .md_rd      (md_rd_int),
        .md_wb_en   (md_wb_int),
        .md_timeout (md_to_int)
    );

    // Everything is forced quiet while reset is held, including the combinational paths.
    assign fwd_a_sel  = reset_n ? fwd_a : FWD_RF;
    assign fwd_b_sel  = reset_n ? fwd_b : FWD_RF;
    assign stall_fd   = reset_n && stall_int;
    assign bubble_dx  = reset_n && stall_int;
    assign md_busy    = reset_n && md_busy_int;
    assign md_rd      = reset_n ? md_rd_int : '0;
    assign md_wb_en   = reset_n && md_wb_int;
    assign md_timeout = reset_n && md_to_int;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_q, perf_md_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_q <= '0;
            perf_md_q    <= '0;
        end else begin
            if (stall_int && perf_stall_q != '1)   perf_stall_q <= perf_stall_q + 1'b1;
            if (md_busy_int && perf_md_q != '1)    perf_md_q    <= perf_md_q + 1'b1;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_md_cnt    = perf_md_q;
`endif

endmodule
